// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4:1 arbitrated mux.
package mux_arb_pkg;
    localparam int unsigned N_REQ = 4;
    typedef logic [1:0] req_idx_t;
endpackage

// File: rtl/mux_arb_4_1_rr_pick_4.sv
// Combinational 4-way picker: first set request searching from start upward, modulo 4.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         start,
    output logic             any,
    output req_idx_t         idx
);
    req_idx_t cand;
    logic     found;

    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = start + req_idx_t'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb_4_1.sv
// Four-requester arbiter feeding one registered output stage over valid/ready.
// Define MUX_ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 always wins first.
module mux_arb_4_1
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             in_valid,
    input  logic [N_REQ-1:0][WIDTH-1:0]  in_data,
    output logic [N_REQ-1:0]             in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output req_idx_t                     out_src,
    input  logic                         out_ready
);
    logic     load;
    logic     any;
    req_idx_t idx;
    req_idx_t start;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    req_idx_t ptr;
    assign start = ptr;
`else
    assign start = '0;
`endif

    rr_pick_4 u_pick (
        .req   (in_valid),
        .start (start),
        .any   (any),
        .idx   (idx)
    );

    assign load = !out_valid || out_ready;

    always_comb begin
        in_ready = '0;
        if (!rst && load && any) begin
            in_ready[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
`ifdef MUX_ARB_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= in_data[idx];
                out_src   <= idx;
`ifdef MUX_ARB_ROUND_ROBIN_EN
                ptr       <= idx + req_idx_t'(1);
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
